// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Conditions a raw, bouncy, asynchronous pushbutton level.
//               The raw level passes through a two-flop synchronizer and a
//               four-state debounce FSM. Two registered outputs are produced:
//               a one-cycle pulse per accepted press, and the debounced level.
//
// Ports       : sClk         - single clock, rising-edge active
//               sReset       - synchronous, active-high reset
//               sButtonRaw   - asynchronous pushbutton level (1 = pressed)
//               sButton      - one-cycle pulse per accepted press
//               sButtonLevel - debounced button level
//
// Parameters  : DEBOUNCE_CYCLES - counter terminal value + 1 (>= 1)
//               CNT_W           - counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic sClk,
  input  logic sReset,
  input  logic sButtonRaw,
  output logic sButton,
  output logic sButtonLevel
);

  // State encoding
  localparam logic [1:0] c_IDLE         = 2'd0;
  localparam logic [1:0] c_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] c_PRESSED      = 2'd2;
  localparam logic [1:0] c_RELEASE_WAIT = 2'd3;

  // Terminal count: the last stable sample before a transition is accepted.
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  // Synchronizer flops; only r_sync2 is seen by the FSM.
  logic             r_sync1;
  logic             r_sync2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_button;
  logic             r_buttonLevel;

  logic [1:0]       w_stateNext;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_pulseNext;
  logic             w_levelNext;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_pulseNext = 1'b0;

    case (r_state)
      c_IDLE: begin
        if (r_sync2) begin
          w_stateNext = c_PRESS_WAIT;
          w_cntNext   = c_CNT_ZERO;
        end
      end

      c_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_stateNext = c_IDLE;
          w_cntNext   = c_CNT_ZERO;
        end else if (r_cnt == c_CNT_LAST) begin
          // Only this path generates the press pulse; re-entry into
          // PRESSED from RELEASE_WAIT is a bounce, not a new press.
          w_stateNext = c_PRESSED;
          w_pulseNext = 1'b1;
        end else begin
          w_cntNext   = r_cnt + c_CNT_ONE;
        end
      end

      c_PRESSED: begin
        if (!r_sync2) begin
          w_stateNext = c_RELEASE_WAIT;
          w_cntNext   = c_CNT_ZERO;
        end
      end

      c_RELEASE_WAIT: begin
        if (r_sync2) begin
          w_stateNext = c_PRESSED;
          w_cntNext   = c_CNT_ZERO;
        end else if (r_cnt == c_CNT_LAST) begin
          w_stateNext = c_IDLE;
        end else begin
          w_cntNext   = r_cnt + c_CNT_ONE;
        end
      end

      default: begin
        w_stateNext = c_IDLE;
        w_cntNext   = c_CNT_ZERO;
      end
    endcase
  end

  // The level output is registered from the next state so that it tracks
  // the state register exactly, without an extra cycle of lag.
  assign w_levelNext = (w_stateNext == c_PRESSED) ||
                       (w_stateNext == c_RELEASE_WAIT);

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------
  always_ff @(posedge sClk) begin
    if (sReset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_state       <= c_IDLE;
      r_cnt         <= c_CNT_ZERO;
      r_button      <= 1'b0;
      r_buttonLevel <= 1'b0;
    end else begin
      r_sync1       <= sButtonRaw;
      r_sync2       <= r_sync1;
      r_state       <= w_stateNext;
      r_cnt         <= w_cntNext;
      r_button      <= w_pulseNext;
      r_buttonLevel <= w_levelNext;
    end
  end

  assign sButton      = r_button;
  assign sButtonLevel = r_buttonLevel;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner. A reference model
//               treats the synchronized input as the raw input delayed by two
//               samples and accepts a level change after DEBOUNCE_CYCLES+1
//               consecutive differing samples. Directed scenarios add
//               explicit edge-exact checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int c_DEB   = 4;
  localparam int c_CNT_W = 3;

  logic clk;
  logic rst;
  logic raw;
  logic sButton;
  logic sButtonLevel;

  int nVectors     = 0;
  int nMiscompares = 0;

  // Reference model state
  bit q[$];        // raw samples still travelling through the synchronizer
  bit mLevel;      // accepted level
  int mRun;        // consecutive samples differing from the accepted level
  bit mPulse;

  button_conditioner #(
    .DEBOUNCE_CYCLES (c_DEB),
    .CNT_W           (c_CNT_W)
  ) dut (
    .sClk         (clk),
    .sReset       (rst),
    .sButtonRaw   (raw),
    .sButton      (sButton),
    .sButtonLevel (sButtonLevel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic obs, input logic exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic modelEdge(input bit r, input bit rs);
    bit s;
    if (rs) begin
      q      = '{1'b0, 1'b0};
      mLevel = 1'b0;
      mRun   = 0;
      mPulse = 1'b0;
    end else begin
      s = q.pop_front();
      q.push_back(r);
      mPulse = 1'b0;
      if (s != mLevel) begin
        mRun++;
        if (mRun == c_DEB + 1) begin
          mLevel = s;
          mRun   = 0;
          mPulse = s;
        end
      end else begin
        mRun = 0;
      end
    end
  endtask

  // Drive inputs, take one edge, sample #1 later and compare with the model.
  task automatic step(input bit r, input bit rs);
    raw = r;
    rst = rs;
    @(posedge clk);
    modelEdge(r, rs);
    #1;
    checkValue("model_pulse", sButton, mPulse);
    checkValue("model_level", sButtonLevel, mLevel);
  endtask

  initial begin
    int hold;
    bit lvl;
    q      = '{1'b0, 1'b0};
    mLevel = 1'b0;
    mRun   = 0;
    mPulse = 1'b0;
    raw    = 1'b0;
    rst    = 1'b1;
    #2;

    // Reset held for two edges with the raw input pressed
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1);
      checkValue("reset_pulse", sButton, 1'b0);
      checkValue("reset_level", sButtonLevel, 1'b0);
    end
    step(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0);

    // Clean press: pulse only after E6, level from E6 onward
    for (int k = 0; k <= 10; k++) begin
      step(1'b1, 1'b0);
      checkValue("press_pulse", sButton, (k == 6));
      checkValue("press_level", sButtonLevel, (k >= 6));
    end

    // Release bounce: two low cycles then high again
    for (int k = 0; k < 12; k++) begin
      step((k < 2) ? 1'b0 : 1'b1, 1'b0);
      checkValue("bounce_pulse", sButton, 1'b0);
      checkValue("bounce_level", sButtonLevel, 1'b1);
    end

    // Full release held 10 cycles
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0);
      checkValue("release_level", sButtonLevel, (k < 6));
      checkValue("release_pulse", sButton, 1'b0);
    end

    // Re-press: exactly one pulse, after the sixth edge
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0);
      checkValue("repress_pulse", sButton, (k == 6));
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);

    // Press glitch: high before E0, low before E3
    for (int k = 0; k < 12; k++) begin
      step((k < 3) ? 1'b1 : 1'b0, 1'b0);
      checkValue("glitch_pulse", sButton, 1'b0);
      checkValue("glitch_level", sButtonLevel, 1'b0);
    end

    // Reset mid-debounce: edges E0..E4 bring the FSM to PRESS_WAIT, cnt=2
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checkValue("midrst_pulse", sButton, 1'b0);
    checkValue("midrst_level", sButtonLevel, 1'b0);
    for (int k = 0; k <= 9; k++) begin
      step(1'b1, 1'b0);
      checkValue("midrst_after_pulse", sButton, (k == 6));
      checkValue("midrst_after_level", sButtonLevel, (k >= 6));
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);

    // Randomized bouncy stimulus with occasional resets
    lvl = 1'b0;
    for (int seg = 0; seg < 600; seg++) begin
      lvl  = ~lvl;
      hold = (($urandom % 4) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 6);
      for (int k = 0; k < hold; k++) begin
        step(lvl, ($urandom % 250) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
`default_nettype wire
